// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the ALU; results go to memory access like an ALU result.
// Define MULDIV_FAST_MUL_EN for a single-cycle 33x33 multiplier; divides always take 32 iterations.
module muldiv_unit (
  input  logic        clk,
  input  logic        rstd,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] EM_result,
  output logic [4:0]  EM_rd_addr,
  output logic [31:0] EM_pc,
  output logic        EM_w_enable
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             op_q;
  logic [4:0]             rd_q;
  logic [XLEN-1:0]        pc_q;
  logic                   neg_q;
  logic [2*XLEN-1:0]      acc_q;
  logic [XLEN-1:0]        opb_q;

  // Operand decode: signedness, magnitudes, result sign
  logic            is_mul, a_signed, b_signed, sa, sb, neg_c;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_mul   = ~funct3[2];
  assign a_signed = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
  assign b_signed = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
  assign sa       = a_signed & rs1_data[XLEN-1];
  assign sb       = b_signed & rs2_data[XLEN-1];
  assign abs_a    = sa ? (~rs1_data + 32'd1) : rs1_data;
  assign abs_b    = sb ? (~rs2_data + 32'd1) : rs2_data;
  assign neg_c    = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);

  // Operations that bypass CALC and finish in a single cycle
  logic            div_zero, div_ovf, special_c;
  logic [XLEN-1:0] special_res;

  assign div_zero = funct3[2] & (rs2_data == 32'd0);
  assign div_ovf  = funct3[2] & ~funct3[0] &
                    (rs1_data == 32'h8000_0000) & (rs2_data == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fprod;
  assign fa        = 64'($signed({sa, rs1_data}));
  assign fb        = 64'($signed({sb, rs2_data}));
  assign fprod     = fa * fb;
  assign special_c = div_zero | div_ovf | is_mul;
`else
  assign special_c = div_zero | div_ovf;
`endif

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_res = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (is_mul) begin
      special_res = (funct3 == 3'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One shift-add (multiply) or shift-subtract (divide) step
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_next, div_next, step_next;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;

  assign msum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign mul_next  = {msum, acc_q[XLEN-1:1]};
  assign div_ge    = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opb_q};
  assign div_diff  = acc_q[2*XLEN-2:XLEN-1] - opb_q;
  assign div_next  = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
  assign step_next = ~op_q[2] ? mul_next : div_next;

  // Sign fix-up and result selection on the final step
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, final_res;

  assign prod_s = neg_q ? (~step_next + 64'd1) : step_next;
  assign quot_s = neg_q ? (~step_next[XLEN-1:0] + 32'd1) : step_next[XLEN-1:0];
  assign rem_s  = neg_q ? (~step_next[2*XLEN-1:XLEN] + 32'd1) : step_next[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    case (op_q)
      3'd0:             final_res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: final_res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:       final_res = quot_s;
      default:          final_res = rem_s;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rstd) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      opb_q      <= '0;
      EM_result  <= '0;
      EM_rd_addr <= '0;
      EM_pc      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= funct3;
            rd_q  <= rd_addr;
            pc_q  <= pc;
            neg_q <= neg_c;
            cnt_q <= '0;
            // Multiplier sits in the low half so the accumulator shift consumes it
            acc_q <= is_mul ? {32'd0, abs_b} : {32'd0, abs_a};
            opb_q <= is_mul ? abs_a : abs_b;
            if (special_c) begin
              EM_result  <= special_res;
              EM_rd_addr <= rd_addr;
              EM_pc      <= pc;
              state_q    <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= step_next;
          cnt_q <= CNT_W'(cnt_q + 5'd1);
          if (cnt_q == 5'd31) begin
            EM_result  <= final_res;
            EM_rd_addr <= rd_q;
            EM_pc      <= pc_q;
            state_q    <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = (state_q == DONE);
  assign EM_w_enable = done & (EM_rd_addr != 5'd0);
  assign busy        = (state_q == CALC) | ((state_q == IDLE) & start & ~special_c);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU. Accepts one M-extension operation per start pulse, stalls the front of the pipeline while it computes, and presents result, destination register and PC to the memory-access stage in the same form as an ALU result. Division is a 32-iteration restoring divider. Multiplication is either iterative or single-cycle, selected at compile time.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the other pipeline registers.
- rstd  in  1  reset; synchronous, active-high.
- start  in  1  decoded M-extension instruction present in execute; sampled only in IDLE.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  32  operand A (dividend / multiplicand).
- rs2_data  in  32  operand B (divisor / multiplier).
- rd_addr  in  5  destination register.
- pc  in  32  instruction PC.
- busy  out  1  stall request to fetch/decode/execute.
- done  out  1  one-cycle pulse; EM_* outputs valid.
- EM_result  out  32  operation result, fed to memory access as alu_result.
- EM_rd_addr  out  5  latched rd_addr.
- EM_pc  out  32  latched pc.
- EM_w_enable  out  1  1 when done and EM_rd_addr != 0.

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - Latch funct3, rd_addr, pc.
  - Latch absolute values of the operands. Signedness comes from funct3: MULH signed×signed; MULHSU rs1 signed, rs2 unsigned; DIV/REM signed; MULHU/DIVU/REMU/MUL unsigned.
  - Record the result sign: product negative if the signed operand signs differ; quotient negative if the signs differ; remainder takes the sign of the dividend.
  - Go to CALC with iteration counter = 0.
- IDLE, start=1, special cases that skip CALC and go to DONE:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = rs1_data.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC, divide: each edge shifts the 64-bit {remainder, quotient} left by 1 and trial-subtracts the divisor from the upper 33 bits. If the result is non-negative, store it and set quotient bit 0.
- CALC, multiply (iterative): each edge, if multiplier bit 0 = 1, add the multiplicand to the upper half of the 64-bit accumulator; then shift the accumulator and multiplier right by 1. The carry out of the add is retained.
- After iteration 31, go to DONE:
  - Apply the recorded sign by two's-complement negation of the 64-bit product, the quotient, or the remainder.
  - Register EM_result: low 32 bits for MUL, high 32 bits for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start in CALC or DONE is ignored. The upstream stage holds its instruction while busy=1 and deasserts start in the cycle after done.
- busy = (state==CALC) | (state==IDLE & start & not a special case).
- EM_result, EM_rd_addr and EM_pc hold their values until the next DONE.

## Timing
- The cycle in which start is sampled is cycle 0.
- Iterative operation: CALC occupies cycles 1–32; done=1 in cycle 33.
- Special-case divide: done=1 in cycle 1, busy never asserted.
- Back-to-back operations: the earliest next start is sampled in the cycle after done (cycle 34 after the first start).
- Reset (rstd=1 at a falling edge), including mid-CALC:
  - State returns to IDLE and any in-progress operation is discarded with no done.
  - Reset values: done=0, busy=0 (given start=0), EM_result=0, EM_rd_addr=0, EM_pc=0, EM_w_enable=0.
- rstd takes priority over start in the same cycle.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a combinational 33×33 signed multiplier on sign/zero-extended operands.
  - IDLE goes straight to DONE; done=1 in cycle 1 and busy is never asserted for multiplies.
  - Divide behaviour is unchanged.
- Undefined: multiplies use the 32-iteration path; done=1 in cycle 33.

## Test plan
- DIV rs1=0xFFFFFF9C (−100), rs2=7, rd=5 → done in cycle 33, EM_result=0xFFFFFFF2, EM_rd_addr=5, EM_w_enable=1; busy=1 in cycles 0–32. REM with the same operands → 0xFFFFFFFE.
- DIVU rs2=0, rs1=0x12345678 → done in cycle 1, EM_result=0xFFFFFFFF. REMU with the same operands → 0x12345678. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF. MUL 0xFFFFFFFF×3 → 0xFFFFFFFD. Check latency 33 without MULDIV_FAST_MUL_EN and 1 with it.
- rd_addr=0, DIVU 10/3 → EM_result=3, EM_w_enable=0.
- start pulsed with different operands during cycle 10 of a DIVU 100/10 → ignored; result 10; a single done.
- rstd=1 in cycle 15 of a DIV → no done; all outputs 0. A new DIVU 9/2 started afterwards → 4 in cycle 33.
